// File: rtl/switch_ingress_framer.sv
// Ingress framer: per-port FIFOs feed one {src, dst, data} sorter word per port per frame.
// Optional INGRESS_HOLD_EN gathers beats in a small FSM before each emit.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module switch_ingress_framer #(
  parameter int PORT_NUB       = 4,
  parameter int PORT_NUB_TOTAL = `PORT_NUB_TOTAL,
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int PORT_BASE      = 0,
  parameter int FIFO_DEPTH     = 4,
  parameter int HOLD_CYCLES    = 8,
  localparam int SW = $clog2(PORT_NUB_TOTAL),
  localparam int WP = 2*SW + DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORT_NUB-1:0]            in_valid,
  output logic [PORT_NUB-1:0]            in_ready,
  input  logic [PORT_NUB*SW-1:0]         in_dst,
  input  logic [PORT_NUB*DATA_WIDTH-1:0] in_data,
  input  logic                           frame_ready,
  output logic                           frame_valid,
  output logic [PORT_NUB*WP-1:0]         port_out,
  output logic [15:0]                    drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = SW + DATA_WIDTH;

  if (PORT_NUB < 2 || (PORT_NUB & (PORT_NUB - 1)) != 0) begin : g_chk_ports
    $error("PORT_NUB must be a power of two >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("HOLD_CYCLES must be >= 1");
  end

  function automatic logic [PORT_NUB*WP-1:0] idle_frame();
    logic [PORT_NUB*WP-1:0] f;
    f = '0;
    for (int i = 0; i < PORT_NUB; i++) begin
      f[i*WP +: WP] = {SW'(PORT_BASE + i), SW'(PORT_BASE + i), {DATA_WIDTH{1'b0}}};
    end
    return f;
  endfunction

  logic [EW-1:0]         mem_q    [PORT_NUB][FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q [PORT_NUB];
  logic [AW-1:0]         rd_ptr_q [PORT_NUB];
  logic [CW-1:0]         cnt_q    [PORT_NUB];
  logic [CW-1:0]         cnt_d    [PORT_NUB];
  logic [PORT_NUB-1:0]   nonempty, full, self_addr, push, pop, drop;
  logic                  emit;
  logic [PORT_NUB*WP-1:0] port_out_q, port_out_d;
  logic                  frame_valid_q, frame_valid_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic [16:0]           drop_sum;

  // Ready looks only at registered occupancy, so a full FIFO stays closed even while popping.
  always_comb begin
    nonempty  = '0;
    full      = '0;
    in_ready  = '0;
    self_addr = '0;
    push      = '0;
    drop      = '0;
    for (int i = 0; i < PORT_NUB; i++) begin
      nonempty[i]  = (cnt_q[i] != '0);
      full[i]      = (cnt_q[i] == CW'(FIFO_DEPTH));
      in_ready[i]  = ~full[i];
      self_addr[i] = (in_dst[i*SW +: SW] == SW'(PORT_BASE + i));
      drop[i]      = in_valid[i] & in_ready[i] & self_addr[i];
      push[i]      = in_valid[i] & in_ready[i] & ~self_addr[i];
    end
  end

  always_comb begin
    pop           = '0;
    port_out_d    = idle_frame();
    frame_valid_d = 1'b0;
    for (int i = 0; i < PORT_NUB; i++) begin
      pop[i]   = emit & nonempty[i];
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      if (pop[i]) begin
        port_out_d[i*WP +: WP] = {SW'(PORT_BASE + i), mem_q[i][rd_ptr_q[i]]};
        frame_valid_d          = 1'b1;
      end
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int i = 0; i < PORT_NUB; i++) begin
      drop_sum = drop_sum + 17'(drop[i]);
    end
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PORT_NUB; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      port_out_q    <= idle_frame();
      frame_valid_q <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      for (int i = 0; i < PORT_NUB; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
        cnt_q[i] <= cnt_d[i];
      end
      port_out_q    <= port_out_d;
      frame_valid_q <= frame_valid_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PORT_NUB; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= {in_dst[i*SW +: SW], in_data[i*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

`ifdef INGRESS_HOLD_EN
  localparam int HW = $clog2(HOLD_CYCLES) + 1;

  // state   | meaning
  // S_IDLE   | every FIFO empty
  // S_GATHER | beats buffered, waiting for fill or timeout
  // S_EMIT   | one frame goes out at the next edge with frame_ready high
  typedef enum logic [1:0] {S_IDLE, S_GATHER, S_EMIT} state_t;

  state_t        state_q;
  logic [HW-1:0] wait_q;
  logic          any_left;

  always_comb begin
    any_left = 1'b0;
    for (int i = 0; i < PORT_NUB; i++) begin
      any_left = any_left | (cnt_d[i] != '0);
    end
  end

  assign emit = (state_q == S_EMIT) && frame_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (any_left) begin
          state_q <= S_GATHER;
          wait_q  <= '0;
        end
        S_GATHER: begin
          wait_q <= wait_q + HW'(1);
          if ((&nonempty) || (|full) || (wait_q == HW'(HOLD_CYCLES - 1))) state_q <= S_EMIT;
        end
        S_EMIT: if (frame_ready) begin
          wait_q  <= '0;
          state_q <= any_left ? S_GATHER : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
`else
  assign emit = frame_ready & (|nonempty);
`endif

  assign port_out    = port_out_q;
  assign frame_valid = frame_valid_q;
  assign drop_cnt    = drop_cnt_q;

endmodule
